// File: rtl/step_cpu_pkg.sv
// step_cpu_pkg: opcodes, FSM states, instruction field positions and LED select codes
package step_cpu_pkg;
  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LDI  = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_AND  = 3'd4,
    OP_OR   = 3'd5,
    OP_BNZ  = 3'd6,
    OP_HALT = 3'd7
  } opcode_t;
  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;
  localparam int OP_LSB = 9;
  localparam int RD_LSB = 6;
  localparam int RS_LSB = 3;
  localparam int RT_LSB = 0;
  localparam int IMM_W  = 6;
  localparam logic [2:0] LED_REG    = 3'd0;
  localparam logic [2:0] LED_PC     = 3'd1;
  localparam logic [2:0] LED_IR_LO  = 3'd2;
  localparam logic [2:0] LED_IR_HI  = 3'd3;
  localparam logic [2:0] LED_STATUS = 3'd4;
endpackage

// File: rtl/step_cpu_imem.sv
// step_cpu_imem: synchronous-read instruction memory; STEP_CPU_IMEM_WR_EN adds a write port
module step_cpu_imem
  import step_cpu_pkg::*;
#(
  parameter int    ADDR_W    = 6,
  parameter string INIT_FILE = "step_cpu.mif"
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] raddr,
  output logic [11:0]       rdata
`ifdef STEP_CPU_IMEM_WR_EN
  ,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [11:0]       wdata
`endif
);
  // with no image supplied the array parks the core in HALT rather than spinning on NOPs
  localparam logic [11:0] FILL = (INIT_FILE == "") ? {OP_HALT, 9'd0} : 12'h000;
  (* ram_init_file = INIT_FILE *) logic [11:0] mem [2**ADDR_W] = '{default: FILL};
  // one-cycle read; a same-cycle write to the fetched address returns the old word
  always_ff @(posedge clk) begin
`ifdef STEP_CPU_IMEM_WR_EN
    if (we) mem[waddr] <= wdata;
`endif
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/step_cpu.sv
// step_cpu: single-step lab processor; define STEP_CPU_IMEM_WR_EN for a writable instruction memory
module step_cpu
  import step_cpu_pkg::*;
#(
  parameter int    DATA_W    = 8,
  parameter int    ADDR_W    = 6,
  parameter string INIT_FILE = "step_cpu.mif"
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step_mode,
  input  logic              step_n,
  input  logic [2:0]        led_sel,
  input  logic [2:0]        reg_sel,
  output logic [7:0]        led,
  output logic              halted
`ifdef STEP_CPU_IMEM_WR_EN
  ,
  input  logic              imem_we,
  input  logic [ADDR_W-1:0] imem_waddr,
  input  logic [11:0]       imem_wdata
`endif
);
  state_t              state, state_nxt;
  opcode_t             op;
  logic [ADDR_W-1:0]   pc;
  logic [11:0]         instr, rdata;
  logic [DATA_W-1:0]   regs [8];
  logic [DATA_W-1:0]   a, b, res;
  logic [IMM_W-1:0]    imm;
  logic [2:0]          rd, sync;
  logic [7:0]          led_nxt;
  logic                exec, pulse, wr, taken;
  step_cpu_imem #(.ADDR_W(ADDR_W), .INIT_FILE(INIT_FILE)) u_imem (
    .clk(clk),
    .raddr(pc),
    .rdata(rdata)
`ifdef STEP_CPU_IMEM_WR_EN
    ,
    .we(imem_we),
    .waddr(imem_waddr),
    .wdata(imem_wdata)
`endif
  );
  assign op     = opcode_t'(rdata[OP_LSB +: 3]);
  assign rd     = rdata[RD_LSB +: 3];
  assign imm    = rdata[IMM_W-1:0];
  assign a      = regs[rdata[RS_LSB +: 3]];
  assign b      = regs[rdata[RT_LSB +: 3]];
  assign exec   = state == S_EXEC;
  assign pulse  = sync[2] & ~sync[1];
  assign halted = state == S_HALT;
  // ALU, write/branch decode, next state and LED source mux
  always_comb begin
    res = op == OP_LDI ? DATA_W'(imm) : op == OP_ADD ? a + b : op == OP_SUB ? a - b :
          op == OP_AND ? a & b : a | b;
    wr = exec && op inside {OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR};
    taken = op == OP_BNZ && regs[rd] != '0;
    state_nxt = state == S_WAIT  ? ((!step_mode || pulse) ? S_FETCH : S_WAIT) :
                state == S_FETCH ? S_EXEC :
                state == S_EXEC  ? (op == OP_HALT ? S_HALT : step_mode ? S_WAIT : S_FETCH) : S_HALT;
    led_nxt = led_sel == LED_REG    ? 8'(regs[reg_sel]) :
              led_sel == LED_PC     ? 8'(pc) :
              led_sel == LED_IR_LO  ? instr[7:0] :
              led_sel == LED_IR_HI  ? {4'b0, instr[11:8]} :
              led_sel == LED_STATUS ? {5'b0, halted, state} : 8'h00;
  end
  // key synchroniser plus edge history; idle-high reset so release never reads as a press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 3'b111;
    else sync <= {sync[1:0], step_n};
  end
  // FSM, program counter and latched instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_WAIT;
      pc    <= '0;
      instr <= '0;
    end else begin
      state <= state_nxt;
      if (exec) instr <= rdata;
      if (exec && op != OP_HALT) pc <= taken ? ADDR_W'(imm) : pc + 1'b1;
    end
  end
  // register file write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < 8; i++) regs[i] <= '0;
    else if (wr) regs[rd] <= res;
  end
  // registered LED output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led <= '0;
    else led <= led_nxt;
  end
endmodule
